// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM word/state encodings plus the memory arbiter's FSM and
// requester-class encodings.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic {IDLE, XFER} arb_state_t;

  typedef enum logic {CLS_I, CLS_D} arb_class_t;

  localparam int ARB_NCORES = 2;

  // Width of a core index; a single core still needs one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Rotating first-one finder: returns the first set request bit at or after
// start, wrapping modulo N.
module arb_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int c;
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    valid = 1'b0;
    idx   = '0;
    c     = 0;
    for (int k = 0; k < N; k++) begin
      c = int'(start) + k;
      if (c >= N) c = c - N;
      if (!valid && req[c]) begin
        valid = 1'b1;
        idx   = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port among NCORES icache/dcache pairs, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin core rotation; otherwise lowest core index wins.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NCORES = ARB_NCORES,
  parameter int WORD_W = 32
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NCORES-1:0]        iREN,
  input  logic [NCORES*WORD_W-1:0] iaddr,
  output logic [NCORES-1:0]        iwait,
  output logic [NCORES*WORD_W-1:0] iload,
  input  logic [NCORES-1:0]        dREN,
  input  logic [NCORES-1:0]        dWEN,
  input  logic [NCORES*WORD_W-1:0] daddr,
  input  logic [NCORES*WORD_W-1:0] dstore,
  output logic [NCORES-1:0]        dwait,
  output logic [NCORES*WORD_W-1:0] dload,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [WORD_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  input  logic [WORD_W-1:0]        ramload,
  input  ramstate_t                ramstate
);

  localparam int IDX_W = idx_w(NCORES);

  arb_state_t        state;
  arb_class_t        gnt_cls;
  logic [IDX_W-1:0]  gnt_core;
  logic              gnt_wr;
  logic [IDX_W-1:0]  start;
  logic [NCORES-1:0] dreq;
  logic              d_valid, i_valid;
  logic [IDX_W-1:0]  d_idx, i_idx;
  logic              g_iren, g_dren, g_dwen, g_active, done;
  logic [WORD_W-1:0] g_iaddr, g_daddr, g_dstore;
  logic [WORD_W-1:0] iload_q [NCORES];
  logic [WORD_W-1:0] dload_q [NCORES];

  assign dreq = dREN | dWEN;

`ifdef MEM_ARB_RR_EN
  logic [IDX_W-1:0] rr_ptr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)     rr_ptr <= '0;
    else if (done) rr_ptr <= (int'(gnt_core) == NCORES - 1) ? '0 : gnt_core + 1'b1;
  end

  assign start = rr_ptr;
`else
  assign start = '0;
`endif

  arb_pick #(.N(NCORES), .IDX_W(IDX_W)) u_pick_d (
    .req(dreq), .start(start), .valid(d_valid), .idx(d_idx)
  );

  arb_pick #(.N(NCORES), .IDX_W(IDX_W)) u_pick_i (
    .req(iREN), .start(start), .valid(i_valid), .idx(i_idx)
  );

  // RAM side follows the granted requester's live inputs so a dropped enable
  // aborts in the same cycle.
  always_comb begin
    g_iren   = iREN[gnt_core];
    g_dren   = dREN[gnt_core];
    g_dwen   = dWEN[gnt_core];
    g_iaddr  = iaddr[int'(gnt_core)*WORD_W +: WORD_W];
    g_daddr  = daddr[int'(gnt_core)*WORD_W +: WORD_W];
    g_dstore = dstore[int'(gnt_core)*WORD_W +: WORD_W];
    g_active = (gnt_cls == CLS_D) ? (g_dren | g_dwen) : g_iren;
    done     = (state == XFER) && g_active && (ramstate == ACCESS);

    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    if (state == XFER && g_active) begin
      if (gnt_cls == CLS_D) begin
        ramWEN   = g_dwen;
        ramREN   = g_dren & ~g_dwen;
        ramaddr  = g_daddr;
        ramstore = g_dstore;
      end else begin
        ramREN  = g_iren;
        ramaddr = g_iaddr;
      end
    end
    if (done) begin
      if (gnt_cls == CLS_D) dwait[gnt_core] = 1'b0;
      else                  iwait[gnt_core] = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (!nRST) begin
      state    <= IDLE;
      gnt_cls  <= CLS_I;
      gnt_core <= '0;
      gnt_wr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (d_valid) begin
            gnt_core <= d_idx;
            gnt_cls  <= CLS_D;
            gnt_wr   <= dWEN[d_idx];
            state    <= XFER;
          end else if (i_valid) begin
            gnt_core <= i_idx;
            gnt_cls  <= CLS_I;
            gnt_wr   <= 1'b0;
            state    <= XFER;
          end
        end
        XFER: if (!g_active || ramstate == ACCESS) state <= IDLE;
      endcase
    end
  end

  // NOTE: the load buffers are a handful of per-core registers, not a RAM
  // macro, so they take the async reset like any other flop.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int c = 0; c < NCORES; c++) begin
        iload_q[c] <= '0;
        dload_q[c] <= '0;
      end
    end else if (done && !gnt_wr && !ramWEN) begin
      if (gnt_cls == CLS_D) dload_q[gnt_core] <= ramload;
      else                  iload_q[gnt_core] <= ramload;
    end
  end

  for (genvar c = 0; c < NCORES; c++) begin : g_load
    assign iload[c*WORD_W +: WORD_W] = iload_q[c];
    assign dload[c*WORD_W +: WORD_W] = dload_q[c];
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a latency/error-programmable RAM model
// plus a scoreboard of expected grants checked whenever a wait pulses low.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int NC = 2;
  localparam int W  = 32;

  logic            CLK = 1'b0;
  logic            nRST = 1'b0;
  logic [NC-1:0]   iREN = '0, dREN = '0, dWEN = '0;
  logic [NC*W-1:0] iaddr = '0, daddr = '0, dstore = '0;
  logic [NC-1:0]   iwait, dwait;
  logic [NC*W-1:0] iload, dload;
  logic            ramREN, ramWEN;
  logic [W-1:0]    ramaddr, ramstore, ramload;
  ramstate_t       ramstate;

  mem_arbiter #(.NCORES(NC), .WORD_W(W)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // RAM model: err_n ERROR cycles, then lat BUSY cycles, then ACCESS.
  int lat = 1;
  int err_n = 0;
  int ram_cyc = 0;

  function automatic logic [31:0] ram_read(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'hC0DE_F00D);
  endfunction

  always_comb begin
    ramstate = FREE;
    if (ramREN || ramWEN) begin
      if (ram_cyc < err_n)            ramstate = ERROR;
      else if (ram_cyc < err_n + lat) ramstate = BUSY;
      else                            ramstate = ACCESS;
    end
  end

  assign ramload = ram_read(ramaddr);

  always @(posedge CLK) begin
    if (!(ramREN || ramWEN) || ramstate == ACCESS) ram_cyc <= 0;
    else                                           ram_cyc <= ram_cyc + 1;
  end

  typedef struct {
    bit          d;
    int          core;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_push = 0;

  task automatic push(input bit d, input int core, input bit wr,
                      input logic [31:0] addr, input logic [31:0] store);
    exp_t e;
    e.d     = d;
    e.core  = core;
    e.wr    = wr;
    e.addr  = addr;
    e.store = store;
    e.data  = wr ? 32'h0 : ram_read(addr);
    sb.push_back(e);
    n_push++;
  endtask

  // Completion monitor, sampling on the falling edge.
  int          done_cnt = 0;
  int          wen_cnt = 0;
  bit          ld_pend = 1'b0;
  bit          ld_d;
  int          ld_core;
  logic [31:0] ld_exp;
  int          obs_core;
  bit          obs_d;
  exp_t        cur;

  always @(negedge CLK) begin
    if (nRST) begin
      if (ramWEN) wen_cnt++;
      if (ld_pend) begin
        if (ld_d) check("dload", dload[ld_core*W +: W], ld_exp);
        else      check("iload", iload[ld_core*W +: W], ld_exp);
        ld_pend = 1'b0;
      end
      if ((~iwait | ~dwait) != '0) begin
        done_cnt++;
        check("one_wait_low", $countones({~iwait, ~dwait}), 1);
        obs_d    = ((~dwait) != '0);
        obs_core = 0;
        for (int c = NC - 1; c >= 0; c--)
          if (!iwait[c] || !dwait[c]) obs_core = c;
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          cur = sb.pop_front();
          check("gnt_class", obs_d, cur.d);
          check("gnt_core", obs_core, cur.core);
          check("ramaddr", ramaddr, cur.addr);
          check("ramWEN", ramWEN, cur.wr);
          if (cur.wr) begin
            check("ramstore", ramstore, cur.store);
          end else begin
            check("ramREN", ramREN, 1);
            ld_pend = 1'b1;
            ld_d    = cur.d;
            ld_core = cur.core;
            ld_exp  = cur.data;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_done(input int target, input string tag);
    int n;
    n = 0;
    do begin
      @(posedge CLK);
      n++;
    end while (done_cnt < target && n < 60);
    #1;
    check(tag, done_cnt >= target, 1);
  endtask

  task automatic pulse_reset();
    nRST = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
  endtask

  initial begin
    int base;
    int wbase;
    int core;

    // Reset state
    #12;
    check("rst_ramREN", ramREN, 0);
    check("rst_ramWEN", ramWEN, 0);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_ramstore", ramstore, 0);
    check("rst_iwait", iwait, 2'b11);
    check("rst_dwait", dwait, 2'b11);
    check("rst_iload", iload, 0);
    check("rst_dload", dload, 0);
    tick();
    nRST = 1'b1;
    tick();

    // Single icache fetch, ACCESS two cycles after the request
    lat = 1;
    base  = done_cnt;
    wbase = wen_cnt;
    iREN[0] = 1'b1;
    iaddr[0*W +: W] = 32'h100;
    push(0, 0, 0, 32'h100, 32'h0);
    @(negedge CLK);
    check("t1_idle_no_ren", ramREN, 0);
    @(negedge CLK);
    check("t1_ren_cycle1", ramREN, 1);
    check("t1_addr", ramaddr, 32'h100);
    check("t1_wait_busy", iwait[0], 1);
    wait_done(n_push, "t1_done");
    iREN[0] = 1'b0;
    repeat (3) tick();
    check("t1_one_pulse", done_cnt - base, 1);
    check("t1_no_wen", wen_cnt - wbase, 0);

    // dcache write beats a simultaneous icache fetch; one IDLE cycle between
    lat = 0;
    iREN[0] = 1'b1;
    dWEN[1] = 1'b1;
    daddr[1*W +: W]  = 32'h200;
    dstore[1*W +: W] = 32'h1234_5678;
    push(1, 1, 1, 32'h200, 32'h1234_5678);
    push(0, 0, 0, 32'h100, 32'h0);
    wait_done(n_push - 1, "t2_write_done");
    dWEN[1] = 1'b0;
    @(negedge CLK);
    check("t2_gap_ren", ramREN, 0);
    check("t2_gap_wen", ramWEN, 0);
    wait_done(n_push, "t2_fetch_done");
    iREN[0] = 1'b0;
    tick();

    // Both cores hold dREN from a fresh reset
    pulse_reset();
    lat = 0;
    daddr[0*W +: W] = 32'h400;
    daddr[1*W +: W] = 32'h500;
    dREN = 2'b11;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      core = k % 2;
`else
      core = 0;
`endif
      push(1, core, 0, (core == 0) ? 32'h400 : 32'h500, 32'h0);
    end
    wait_done(n_push, "t3_done");
    dREN = '0;
    tick();

    // ERROR retried three times before ACCESS
    err_n = 3;
    lat   = 0;
    dREN[0] = 1'b1;
    daddr[0*W +: W] = 32'h600;
    push(1, 0, 0, 32'h600, 32'h0);
    @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("t4_err_dwait", dwait[0], 1);
      check("t4_err_ren", ramREN, 1);
      check("t4_err_addr", ramaddr, 32'h600);
    end
    wait_done(n_push, "t4_done");
    dREN[0] = 1'b0;
    err_n = 0;
    tick();

    // Abort: core1 drops iREN mid-transfer
    lat  = 5;
    base = done_cnt;
    iREN[1] = 1'b1;
    iaddr[1*W +: W] = 32'h700;
    @(negedge CLK);
    check("t5_idle_no_ren", ramREN, 0);
    @(negedge CLK);
    check("t5_ren", ramREN, 1);
    check("t5_addr", ramaddr, 32'h700);
    tick();
    iREN[1] = 1'b0;
    @(negedge CLK);
    check("t5_abort_ren", ramREN, 0);
    check("t5_abort_iwait", iwait, 2'b11);
    tick();
    @(negedge CLK);
    check("t5_idle_after", ramREN, 0);
    check("t5_no_pulse", done_cnt - base, 0);
    // Rotation pointer must be where the last completion left it
    lat = 0;
    iaddr[0*W +: W] = 32'h800;
    iREN = 2'b11;
`ifdef MEM_ARB_RR_EN
    core = 1;
`else
    core = 0;
`endif
    push(0, core, 0, (core == 0) ? 32'h800 : 32'h700, 32'h0);
    wait_done(n_push, "t5_regrant_done");
    iREN = '0;
    tick();

    // Reset in the middle of a write with another request pending
    lat = 5;
    dWEN[1] = 1'b1;
    daddr[1*W +: W]  = 32'h900;
    dstore[1*W +: W] = 32'hCAFE_0001;
    tick();
    dREN[0] = 1'b1;
    daddr[0*W +: W] = 32'hA00;
    @(negedge CLK);
    check("t6_wen_before", ramWEN, 1);
    #1 nRST = 1'b0;
    #1;
    check("t6_rst_wen", ramWEN, 0);
    check("t6_rst_ren", ramREN, 0);
    check("t6_rst_iwait", iwait, 2'b11);
    check("t6_rst_dwait", dwait, 2'b11);
    check("t6_rst_dload", dload, 0);
    check("t6_rst_iload", iload, 0);
    tick();
    tick();
    lat = 0;
    push(1, 0, 0, 32'hA00, 32'h0);
    push(1, 1, 1, 32'h900, 32'hCAFE_0001);
    nRST = 1'b1;
    wait_done(n_push - 1, "t6_core0_done");
    dREN[0] = 1'b0;
    wait_done(n_push, "t6_core1_done");
    dWEN[1] = 1'b0;
    repeat (2) tick();

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
